// File: rtl/cla_multiword_seq_if.sv
// Request/result bundle for the sequential multi-word CLA adder.
// The requester drives the master side and the adder sits on the slave side.
interface cla_multiword_seq_if #(
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = 16 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_multiword_seq.sv
// Sequential WORDS x 16-bit adder: one shared 16-bit CLA is reused per slice,
// least-significant slice first, with the inter-slice carry held in a register.
module cla16bits (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout,
    output logic        gen,
    output logic        prop
);
    // Carries c0..c3 of a 4-position lookahead stage.
    function automatic logic [3:0] la4(input logic [3:0] g, input logic [3:0] p, input logic c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    function automatic logic grp_g(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_c;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [3:0]  w_gc;

    assign w_g = a & b;
    assign w_p = a ^ b;

    for (genvar j = 0; j < 4; j++) begin : g_grp
        assign w_gg[j]       = grp_g(w_g[4*j +: 4], w_p[4*j +: 4]);
        assign w_gp[j]       = &w_p[4*j +: 4];
        assign w_c[4*j +: 4] = la4(w_g[4*j +: 4], w_p[4*j +: 4], w_gc[j]);
    end

    assign w_gc = la4(w_gg, w_gp, cin);
    assign gen  = grp_g(w_gg, w_gp);
    assign prop = &w_gp;
    assign cout = gen | (prop & cin);
    assign s    = w_p ^ w_c;
endmodule

module cla_multiword_seq #(
    parameter int unsigned WORDS = 4
) (
    input logic               clk,
    input logic               rst_n,
    cla_multiword_seq_if.slave bus
);
    localparam int unsigned W  = 16 * WORDS;
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    // One-hot so in_ready/out_valid are direct flop outputs.
    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_RUN  = 3'b010;
    localparam logic [2:0] S_DONE = 3'b100;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic          r_cout;
    logic          r_ovf;

    logic          w_accept;
    logic          w_run;
    logic          w_last;
    logic [15:0]   w_sl_a;
    logic [15:0]   w_sl_b;
    logic [15:0]   w_s;
    logic          w_cout;
    logic          w_unused_gen;
    logic          w_unused_prop;

    assign w_accept = bus.in_valid & r_state[0];
    assign w_run    = r_state[1];
    assign w_last   = (r_idx == IW'(WORDS - 1));

    // Slice select feeding the shared CLA.
    always_comb begin
        w_sl_a = '0;
        w_sl_b = '0;
        for (int k = 0; k < int'(WORDS); k++) begin
            if (r_idx == IW'(k)) begin
                w_sl_a = r_a[16*k +: 16];
                w_sl_b = r_b[16*k +: 16];
            end
        end
    end

    cla16bits u_cla (
        .a    (w_sl_a),
        .b    (w_sl_b),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout),
        .gen  (w_unused_gen),
        .prop (w_unused_prop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)        w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture and per-slice accumulation; result holds until the next RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_idx   <= '0;
        end else if (w_run) begin
            for (int k = 0; k < int'(WORDS); k++) begin
                if (r_idx == IW'(k)) r_sum[16*k +: 16] <= w_s;
            end
            r_carry <= w_cout;
            r_idx   <= r_idx + IW'(1);
            if (w_last) begin
                r_cout <= w_cout;
                r_ovf  <= (r_a[W-1] == r_b[W-1]) & (w_s[15] != r_a[W-1]);
            end
        end
    end

    assign bus.in_ready  = r_state[0];
    assign bus.out_valid = r_state[2];
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
endmodule
